bilbo_sig_cp: RTL and testbench

- Parametrised BILBO register for datapath built-in self-test.
- Five operating modes, one per cycle:
  - normal parallel load
  - serial scan shift
  - pseudo-random pattern generation (PRPG)
  - multiple-input signature register (MISR)
  - synchronous clear
- Adds a session sequencer: a START pulse runs PRPG or MISR for LEN cycles, stops, then reports DONE and PASS against a golden signature.
- Sits at the boundary of a datapath group as its BIST generator or compactor.

---
 rtl/bilbo_sig_cp.sv | 109 ++++++++++
 tb/tb_bilbo_sig_cp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bilbo_sig_cp.sv
// BILBO register (load / scan / PRPG / MISR / clear) with a START-driven
// self-test session sequencer that compares the final signature to GOLDEN.
module bilbo_sig_cp #(
  parameter int             N     = 8,
  parameter logic [N-1:0]   POLY  = 8'hB8,
  parameter logic [N-1:0]   SEED  = 8'h01,
  parameter int             CNT_W = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [2:0]       MODE,
  input  logic [N-1:0]     D,
  input  logic             SDI,
  input  logic             START,
  input  logic [CNT_W-1:0] LEN,
  input  logic [N-1:0]     GOLDEN,
  output logic [N-1:0]     Q,
  output logic             SDO,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS
);

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SCAN = 3'd2;
  localparam logic [2:0] M_PRPG = 3'd3;
  localparam logic [2:0] M_MISR = 3'd4;
  localparam logic [2:0] M_CLR  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       run_mode;
  logic [2:0]       act_mode;
  logic [N-1:0]     q_nxt;
  logic             fb;
  logic             start_ok;
  logic             mode_hold;

  assign fb        = ^(Q & POLY);
  assign SDO       = Q[N-1];
  assign start_ok  = START && (MODE == M_PRPG || MODE == M_MISR);
  assign mode_hold = (MODE == M_HOLD) || (MODE > M_CLR);

  // While a session runs the latched mode owns the register, not MODE.
  assign act_mode = (state == S_RUN) ? run_mode : MODE;

  always_comb begin
    q_nxt = Q;
    case (act_mode)
      M_LOAD:  q_nxt = D;
      M_SCAN:  q_nxt = {Q[N-2:0], SDI};
      M_PRPG:  q_nxt = (Q == '0) ? SEED : {Q[N-2:0], fb};
      M_MISR:  q_nxt = {Q[N-2:0], fb} ^ D;
      M_CLR:   q_nxt = '0;
      default: q_nxt = Q;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= S_IDLE;
      Q        <= '0;
      cnt      <= '0;
      run_mode <= M_PRPG;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          Q   <= q_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (q_nxt == GOLDEN);
          end
        end
        default: begin
          // IDLE and DONE share start handling; DONE only leaves on a real mode action.
          if (start_ok) begin
            if (LEN != '0) begin
              state    <= S_RUN;
              BUSY     <= 1'b1;
              DONE     <= 1'b0;
              PASS     <= 1'b0;
              cnt      <= LEN;
              run_mode <= MODE;
            end else begin
              state <= S_DONE;
              DONE  <= 1'b1;
              PASS  <= (Q == GOLDEN);
            end
          end else if (state != S_DONE || !mode_hold) begin
            state <= S_IDLE;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
            Q     <= q_nxt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bilbo_sig_cp.sv
// Randomized bench for bilbo_sig_cp against a per-operation arithmetic model.
module tb_bilbo_sig_cp;
  localparam int         N      = 8;
  localparam int         CNT_W  = 16;
  localparam logic [7:0] POLY_M = 8'hB8;
  localparam logic [7:0] SEED_M = 8'h01;

  logic             CLK = 1'b0;
  logic             CLR;
  logic [2:0]       MODE;
  logic [N-1:0]     D;
  logic             SDI;
  logic             START;
  logic [CNT_W-1:0] LEN;
  logic [N-1:0]     GOLDEN;
  logic [N-1:0]     Q;
  logic             SDO, BUSY, DONE, PASS;

  int         n_chk = 0;
  int         n_bad = 0;
  logic [7:0] mq;
  bit         mdone, mpass;
  logic [7:0] dv[64];
  logic [7:0] obs[$];

  bilbo_sig_cp #(.N(N), .POLY(POLY_M), .SEED(SEED_M), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .CLR(CLR), .MODE(MODE), .D(D), .SDI(SDI), .START(START),
    .LEN(LEN), .GOLDEN(GOLDEN), .Q(Q), .SDO(SDO), .BUSY(BUSY), .DONE(DONE),
    .PASS(PASS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One register update, computed with integer arithmetic from the mode rules.
  function automatic logic [7:0] m_step(int mode, logic [7:0] q, logic [7:0] d, bit sdi);
    int taps, sh;
    taps = 0;
    for (int i = 0; i < 8; i++) if (POLY_M[i] && q[i]) taps++;
    sh = (int'(q) * 2) % 256;
    case (mode)
      1:       return d;
      2:       return 8'(sh + int'(sdi));
      3:       return (q == 8'h00) ? SEED_M : 8'(sh + taps % 2);
      4:       return 8'(sh + taps % 2) ^ d;
      5:       return 8'h00;
      default: return q;
    endcase
  endfunction

  task automatic do_op(int mode, logic [7:0] d, bit sdi, bit st);
    MODE = 3'(mode); D = d; SDI = sdi; START = st;
    LEN = 16'($urandom_range(1, 9));
    tick;
    START = 1'b0;
    mq = m_step(mode, mq, d, sdi);
    if (!(mode == 0 || mode > 5)) begin mdone = 0; mpass = 0; end
    chk("op_q", Q, mq);
    chk("op_sdo", SDO, mq[7]);
    chk("op_done", DONE, mdone);
    chk("op_pass", PASS, mpass);
    chk("op_busy", BUSY, 0);
  endtask

  // gsel=1: GOLDEN chosen at random as right or wrong; gsel=0: GOLDEN = gin.
  task automatic session(int mode, int len, bit gsel, logic [7:0] gin, bit noisy);
    logic [7:0] eq, gold;
    int cyc;
    eq = mq;
    for (int k = 0; k < len; k++) eq = m_step(mode, eq, dv[k], 1'b0);
    gold = gin;
    if (gsel) gold = ($urandom_range(0, 1) != 0) ? eq : eq ^ 8'h5A;
    obs.delete();
    MODE = 3'(mode); START = 1'b1; LEN = 16'(len); GOLDEN = gold; D = 8'($urandom);
    tick;
    START = 1'b0;
    if (len == 0) begin
      chk("len0_q", Q, mq);
      chk("len0_busy", BUSY, 0);
      chk("len0_done", DONE, 1);
      chk("len0_pass", PASS, mq == gold);
    end else begin
      chk("start_busy", BUSY, 1);
      chk("start_q", Q, mq);
      chk("start_done", DONE, 0);
      cyc = 0;
      while (BUSY === 1'b1 && cyc < len + 5) begin
        D = dv[cyc];
        if (noisy) begin
          MODE  = 3'($urandom_range(0, 7));
          START = 1'($urandom_range(0, 1));
          LEN   = 16'($urandom_range(1, 3));
        end
        tick;
        obs.push_back(Q);
        cyc++;
      end
      MODE = 3'd0; START = 1'b0;
      chk("busy_len", cyc, len);
      chk("sess_q", Q, eq);
      chk("sess_done", DONE, 1);
      chk("sess_pass", PASS, eq == gold);
    end
    mq = eq; mdone = 1; mpass = (eq == gold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pseq[5];
    logic [7:0] mseq[3];
    logic [7:0] pat;
    pseq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    mseq = '{8'hFF, 8'h01, 8'hFD};
    pat  = 8'hA5;

    CLR = 1'b1; MODE = 3'd0; D = '0; SDI = 1'b0; START = 1'b0; LEN = '0; GOLDEN = '0;
    #3;
    chk("rst_q", Q, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_pass", PASS, 0);
    tick;
    CLR = 1'b0;
    mq = 8'h00; mdone = 0; mpass = 0;

    // PRPG from zero: seed escape then LFSR; D must not matter
    do_op(5, 8'h00, 0, 0);
    for (int k = 0; k < 64; k++) dv[k] = 8'($urandom);
    session(3, 5, 0, 8'h11, 0);
    for (int i = 0; i < 5; i++) chk("prpg_seq", obs[i], pseq[i]);
    chk("prpg_pass", PASS, 1);
    do_op(5, 8'h00, 0, 0);
    session(3, 5, 0, 8'h12, 0);
    chk("prpg_q", Q, 8'h11);
    chk("prpg_fail", PASS, 0);

    // MISR with D held at FF
    do_op(1, 8'h00, 0, 0);
    for (int k = 0; k < 64; k++) dv[k] = 8'hFF;
    session(4, 3, 0, 8'hFD, 0);
    for (int i = 0; i < 3; i++) chk("misr_seq", obs[i], mseq[i]);
    chk("misr_pass", PASS, 1);

    // DONE holds on MODE=0, exits on clear
    do_op(0, 8'h77, 0, 0);
    chk("done_hold", DONE, 1);
    do_op(5, 8'h00, 0, 0);
    chk("done_exit", DONE, 0);
    do_op(1, 8'h96, 0, 0);

    // scan A5 in MSB first, then shift it back out through SDO
    for (int i = 7; i >= 0; i--) do_op(2, 8'h00, pat[i], 0);
    chk("scan_q", Q, 8'hA5);
    for (int i = 7; i >= 0; i--) begin
      chk("scan_sdo", SDO, pat[i]);
      do_op(2, 8'h00, 0, 0);
    end

    // sequencer edges
    do_op(1, 8'h3C, 0, 0);
    session(3, 0, 0, 8'h3C, 0);
    session(4, 0, 0, 8'h00, 0);
    for (int k = 0; k < 64; k++) dv[k] = 8'($urandom);
    session(3, 10, 1, 8'h00, 1);
    session(4, 12, 1, 8'h00, 1);
    do_op(1, 8'hC3, 0, 1);

    // CLR mid-session acts immediately, then IDLE behaviour resumes
    MODE = 3'd3; START = 1'b1; LEN = 16'd100;
    tick;
    START = 1'b0;
    repeat (36) tick;
    #3;
    CLR = 1'b1;
    #1;
    chk("clr_q", Q, 0);
    chk("clr_busy", BUSY, 0);
    chk("clr_done", DONE, 0);
    MODE = 3'd0;
    @(negedge CLK);
    CLR = 1'b0;
    mq = 8'h00; mdone = 0; mpass = 0;
    tick;
    chk("clr_idle_busy", BUSY, 0);
    do_op(3, 8'h00, 0, 0);

    // randomized mix of single operations and sessions
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        int m;
        bit st;
        m  = $urandom_range(0, 7);
        st = (m != 3 && m != 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        do_op(m, 8'($urandom), 1'($urandom_range(0, 1)), st);
      end else begin
        for (int k = 0; k < 64; k++) dv[k] = 8'($urandom);
        session(3 + $urandom_range(0, 1), $urandom_range(0, 20), 1, 8'h00,
                1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
